// File: rtl/mem_stage_pkg.sv
// Shared widths, access-descriptor bit positions, size codes and FSM states for
// the MEM stage and its load extender.
package mem_stage_pkg;
   localparam int REG_W       = 32;
   localparam int REG_ADDR_W  = 5;
   localparam int DATA_ADDR_W = 32;
   localparam int STALL_W     = 6;

   localparam int MEM_VALID    = 4;
   localparam int MEM_STORE    = 3;
   localparam int MEM_UNSIGNED = 2;
   localparam int STALL_MEM_WB = 4;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   // Index of the final byte of an access; the illegal code 2 behaves as a word.
   function automatic logic [1:0] last_byte(input logic [1:0] size);
      return (size == 2'd2) ? SIZE_WORD : size;
   endfunction
endpackage

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of an assembled little-endian load value.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [REG_W-1:0] raw,
   input  logic [1:0]       size,
   input  logic             is_unsigned,
   output logic [REG_W-1:0] result
);
   always_comb begin
      result = raw;
      case (size)
         SIZE_BYTE: result = {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
         SIZE_HALF: result = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
         default:   result = raw;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: byte-serial load/store engine against an 8-bit memory controller,
// with zero-latency pass-through for non-memory instructions.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic [REG_W-1:0]       mem_rd_data,
   input  logic [REG_ADDR_W-1:0]  mem_rd_addr,
   input  logic [DATA_ADDR_W-1:0] mem_mem_addr,
   input  logic                   mem_rd_e,
   input  logic [4:0]             mem_length,
   input  logic [STALL_W-1:0]     stall,
   output logic                   mc_req,
   output logic                   mc_we,
   output logic [DATA_ADDR_W-1:0] mc_addr,
   output logic [7:0]             mc_wdata,
   input  logic                   mc_done,
   input  logic [7:0]             mc_rdata,
   output logic [REG_W-1:0]       wb_rd_data,
   output logic [REG_ADDR_W-1:0]  wb_rd_addr,
   output logic                   wb_rd_e,
   output logic                   stall_req
);
   mem_state_e             state_reg;
   logic [1:0]             cnt_reg;
   logic [DATA_ADDR_W-1:0] addr_reg;
   logic [REG_W-1:0]       data_reg;
   logic [REG_W-1:0]       asm_reg;
   logic [REG_ADDR_W-1:0]  rd_addr_reg;
   logic                   rd_e_reg;
   logic                   store_reg;
   logic                   unsigned_reg;
   logic [1:0]             size_reg;
   logic [REG_W-1:0]       load_value;
   logic                   capture;
   logic                   byte_done;
   logic                   unused_stall_bits;

   assign unused_stall_bits = ^{stall[STALL_W-1:STALL_MEM_WB+1], stall[STALL_MEM_WB-1:0]};

   assign capture   = rdy && (state_reg == ST_IDLE) && mem_length[MEM_VALID];
   assign byte_done = rdy && (state_reg == ST_BUSY) && mc_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         addr_reg     <= '0;
         data_reg     <= '0;
         rd_addr_reg  <= '0;
         rd_e_reg     <= 1'b0;
         store_reg    <= 1'b0;
         unsigned_reg <= 1'b0;
         size_reg     <= '0;
      end else if (rdy) begin
         case (state_reg)
            ST_IDLE: if (capture) begin
               addr_reg     <= mem_mem_addr;
               data_reg     <= mem_rd_data;
               rd_addr_reg  <= mem_rd_addr;
               rd_e_reg     <= mem_rd_e;
               store_reg    <= mem_length[MEM_STORE];
               unsigned_reg <= mem_length[MEM_UNSIGNED];
               size_reg     <= mem_length[1:0];
               cnt_reg      <= '0;
               state_reg    <= ST_BUSY;
            end
            ST_BUSY: if (mc_done) begin
               if (cnt_reg == last_byte(size_reg)) state_reg <= ST_DONE;
               else                                cnt_reg   <= cnt_reg + 2'd1;
            end
            ST_DONE: if (!stall[STALL_MEM_WB]) state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // One assembly lane per byte; lanes beyond the access size stay cleared.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               asm_reg[8*gi +: 8] <= '0;
            else if (capture)
               asm_reg[8*gi +: 8] <= '0;
            else if (byte_done && !store_reg && cnt_reg == 2'(gi))
               asm_reg[8*gi +: 8] <= mc_rdata;
         end
      end
   endgenerate

   mem_load_ext u_load_ext (
      .raw         (asm_reg),
      .size        (size_reg),
      .is_unsigned (unsigned_reg),
      .result      (load_value)
   );

   always_comb begin
      mc_req     = 1'b0;
      mc_we      = 1'b0;
      mc_addr    = '0;
      mc_wdata   = '0;
      wb_rd_data = '0;
      wb_rd_addr = '0;
      wb_rd_e    = 1'b0;
      stall_req  = 1'b0;
      if (rst) begin
         case (state_reg)
            ST_IDLE: begin
               wb_rd_addr = mem_rd_addr;
               if (mem_length[MEM_VALID]) begin
                  stall_req = 1'b1;
               end else begin
                  wb_rd_data = mem_rd_data;
                  wb_rd_e    = mem_rd_e;
               end
            end
            ST_BUSY: begin
               mc_req     = 1'b1;
               mc_we      = store_reg;
               mc_addr    = addr_reg + {30'd0, cnt_reg};
               mc_wdata   = data_reg[{cnt_reg, 3'b000} +: 8];
               stall_req  = 1'b1;
               wb_rd_addr = rd_addr_reg;
            end
            ST_DONE: begin
               wb_rd_addr = rd_addr_reg;
               if (!store_reg) begin
                  wb_rd_data = load_value;
                  wb_rd_e    = rd_e_reg;
               end
            end
            default: ;
         endcase
         if (wb_rd_addr == '0) wb_rd_e = 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a small byte-wide memory controller model.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [31:0] mem_rd_data;
   logic [4:0]  mem_rd_addr;
   logic [31:0] mem_mem_addr;
   logic        mem_rd_e;
   logic [4:0]  mem_length;
   logic [5:0]  stall;
   logic        mc_req, mc_we, mc_done;
   logic [31:0] mc_addr;
   logic [7:0]  mc_wdata, mc_rdata;
   logic [31:0] wb_rd_data;
   logic [4:0]  wb_rd_addr;
   logic        wb_rd_e, stall_req;

   logic        done_en;
   int          checks = 0;
   int          errors = 0;
   int          req_cycles = 0;
   int          rd_hs = 0;
   int          wr_cnt = 0;
   logic [31:0] wr_addr [0:7];
   logic [7:0]  wr_data [0:7];

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr),
      .mem_mem_addr(mem_mem_addr), .mem_rd_e(mem_rd_e),
      .mem_length(mem_length), .stall(stall),
      .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
      .mc_done(mc_done), .mc_rdata(mc_rdata),
      .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_e(wb_rd_e),
      .stall_req(stall_req)
   );

   // Controller model: completes a byte in the same cycle it is requested.
   assign mc_done = mc_req & done_en;
   always_comb begin
      case (mc_addr)
         32'h100: mc_rdata = 8'h78;
         32'h101: mc_rdata = 8'h56;
         32'h102: mc_rdata = 8'h34;
         32'h103: mc_rdata = 8'h12;
         32'h003: mc_rdata = 8'h80;
         32'h040: mc_rdata = 8'hEF;
         32'h041: mc_rdata = 8'hBE;
         default: mc_rdata = 8'h00;
      endcase
   end

   always @(posedge clk) begin
      if (mc_req) req_cycles++;
      if (mc_req && mc_done && rdy && !mc_we) rd_hs++;
      if (mc_req && mc_done && rdy && mc_we && wr_cnt < 8) begin
         wr_addr[wr_cnt] = mc_addr;
         wr_data[wr_cnt] = mc_wdata;
         wr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] len, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input logic rde);
      mem_length   = len;
      mem_mem_addr = addr;
      mem_rd_data  = data;
      mem_rd_addr  = rd;
      mem_rd_e     = rde;
   endtask

   // Issues an access, counts stall cycles until DONE, samples write-back,
   // then lets MEM/WB capture and replaces the instruction with a bubble.
   task automatic run_access(input logic [4:0] len, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] rd,
                             output int n, output logic [31:0] wbd, output logic wbe);
      drive(len, addr, data, rd, 1'b1);
      #1;
      n = 0;
      while (stall_req && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("timeout", 32'(n), 32'd0);
      wbd = wb_rd_data;
      wbe = wb_rd_e;
      check("done_mc_req", 32'(mc_req), 32'd0);
      tick();
      drive(5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   int          n;
   int          req_before;
   int          hs_before;
   logic [31:0] wbd;
   logic        wbe;

   initial begin
      rst = 1'b0; rdy = 1'b1; stall = 6'd0; done_en = 1'b1;
      drive(5'd0, 32'd0, 32'h1234, 5'd5, 1'b1);
      tick(); tick();
      check("rst_wb_data", wb_rd_data, 32'd0);
      check("rst_wb_e", 32'(wb_rd_e), 32'd0);
      check("rst_mc_req", 32'(mc_req), 32'd0);
      rst = 1'b1;
      #1;

      // ALU pass-through
      req_before = req_cycles;
      check("alu_wb_data", wb_rd_data, 32'h1234);
      check("alu_wb_addr", 32'(wb_rd_addr), 32'd5);
      check("alu_wb_e", 32'(wb_rd_e), 32'd1);
      check("alu_stall", 32'(stall_req), 32'd0);
      tick(); tick();
      check("alu_no_req", 32'(req_cycles - req_before), 32'd0);
      drive(5'd0, 32'd0, 32'h99, 5'd0, 1'b1);
      #1;
      check("alu_r0_e", 32'(wb_rd_e), 32'd0);

      // LW
      run_access(5'b10011, 32'h100, 32'd0, 5'd7, n, wbd, wbe);
      check("lw_stall_cyc", 32'(n), 32'd5);
      check("lw_data", wbd, 32'h12345678);
      check("lw_e", 32'(wbe), 32'd1);

      // LB / LBU
      run_access(5'b10000, 32'h3, 32'd0, 5'd8, n, wbd, wbe);
      check("lb_stall_cyc", 32'(n), 32'd2);
      check("lb_data", wbd, 32'hFFFFFF80);
      run_access(5'b10100, 32'h3, 32'd0, 5'd8, n, wbd, wbe);
      check("lbu_data", wbd, 32'h00000080);

      // Illegal size code behaves as a word
      run_access(5'b10010, 32'h100, 32'd0, 5'd9, n, wbd, wbe);
      check("sz2_stall_cyc", 32'(n), 32'd5);
      check("sz2_data", wbd, 32'h12345678);

      // SH across the address wrap
      wr_cnt = 0;
      run_access(5'b11001, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd10, n, wbd, wbe);
      check("sh_wr_cnt", 32'(wr_cnt), 32'd2);
      check("sh_addr0", wr_addr[0], 32'hFFFFFFFF);
      check("sh_data0", 32'(wr_data[0]), 32'hDD);
      check("sh_addr1", wr_addr[1], 32'h0);
      check("sh_data1", 32'(wr_data[1]), 32'hCC);
      check("sh_wb_e", 32'(wbe), 32'd0);
      check("sh_wb_data", wbd, 32'd0);

      // LW aborted by reset after two bytes, then re-issued
      drive(5'b10011, 32'h100, 32'd0, 5'd7, 1'b1);
      tick(); tick(); tick();
      check("abort_mc_addr", mc_addr, 32'h102);
      rst = 1'b0;
      #1;
      check("abort_mc_req", 32'(mc_req), 32'd0);
      check("abort_stall", 32'(stall_req), 32'd0);
      check("abort_wb_addr", 32'(wb_rd_addr), 32'd0);
      tick();
      rst = 1'b1;
      run_access(5'b10011, 32'h100, 32'd0, 5'd7, n, wbd, wbe);
      check("reissue_cyc", 32'(n), 32'd5);
      check("reissue_data", wbd, 32'h12345678);

      // LH with rdy low mid-access (mc_done held high) and MEM/WB stalled in DONE
      hs_before = rd_hs;
      drive(5'b10001, 32'h40, 32'd0, 5'd3, 1'b1);
      tick();
      rdy = 1'b0;
      tick(); tick(); tick();
      check("rdy0_addr", mc_addr, 32'h40);
      check("rdy0_hs", 32'(rd_hs - hs_before), 32'd0);
      check("rdy0_stall", 32'(stall_req), 32'd1);
      rdy = 1'b1;
      stall = 6'b010000;
      tick();
      check("lh_byte1_addr", mc_addr, 32'h41);
      tick(); tick(); tick();
      check("lh_held_req", 32'(mc_req), 32'd0);
      check("lh_held_data", wb_rd_data, 32'hFFFFBEEF);
      check("lh_held_e", 32'(wb_rd_e), 32'd1);
      check("lh_held_stall", 32'(stall_req), 32'd0);
      stall = 6'd0;
      tick();
      drive(5'd0, 32'd0, 32'h55, 5'd4, 1'b1);
      req_before = req_cycles;
      tick(); tick();
      check("lh_hs_total", 32'(rd_hs - hs_before), 32'd2);
      check("lh_no_reissue", 32'(req_cycles - req_before), 32'd0);
      check("post_passthru", wb_rd_data, 32'h55);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
